fios_operand_io: RTL

- Host-side endpoint of the FIOS multiplier handshake.
- Stores operands A, B and P as s words of 17 bits each.
- Serves those operands in response to the multiplier's a_shift / b_fetch / p_fetch strobes.
- Issues start, captures the result stream on RES_push, and reports completion on done.
- Sits between a host load/readback port and the FIOS top level.

---
 rtl/fios_io_pkg.sv | 17 +
 rtl/fios_word_ram.sv | 58 +++++
 rtl/fios_operand_io.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fios_io_pkg.sv
// Shared types and constants for the FIOS operand I/O endpoint.
package fios_io_pkg;

    localparam int unsigned WORD_W = 17;

    // Host load select encodings; 2'd3 is reserved.
    localparam logic [1:0] LD_A = 2'd0;
    localparam logic [1:0] LD_B = 2'd1;
    localparam logic [1:0] LD_P = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

endpackage

// File: rtl/fios_word_ram.sv
// Depth x WORD_W word RAM: one sync write port, one async read port, optional
// registered read output (sync active-low reset of the output register only).
module fios_word_ram
    import fios_io_pkg::*;
#(
    parameter int unsigned Depth   = 8,
    parameter int unsigned AW      = $clog2(Depth + 1),
    parameter bit          RegRead = 1'b0
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    localparam int unsigned IW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [WORD_W-1:0] mem_q [Depth];
    logic [WORD_W-1:0] rd_word;

    // Storage write; out-of-range addresses are dropped.
    always_ff @(posedge clock_i) begin
        if (we_i && (32'(waddr_i) < Depth)) begin
            mem_q[waddr_i[IW-1:0]] <= wdata_i;
        end
    end

    // Async read, out-of-range reads return zero.
    always_comb begin
        rd_word = '0;
        if (32'(raddr_i) < Depth) begin
            rd_word = mem_q[raddr_i[IW-1:0]];
        end
    end

    if (RegRead) begin : g_reg_read
        logic [WORD_W-1:0] rdata_q;

        // Registered read data, cleared on reset.
        always_ff @(posedge clock_i) begin
            if (!reset_i) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rd_word;
            end
        end

        assign rdata_o = rdata_q;
    end else begin : g_comb_read
        logic unused_reset;
        assign unused_reset = reset_i;
        assign rdata_o      = rd_word;
    end

endmodule

// File: rtl/fios_operand_io.sv
// Host-side endpoint of the FIOS multiplier handshake: holds A/B/P operands,
// serves them on the multiplier's strobes and captures the result stream.
module fios_operand_io
    import fios_io_pkg::*;
#(
    parameter int unsigned s     = 8,
    parameter int unsigned PE_NB = 8,
    parameter int unsigned AW    = $clog2(s + 1)
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    ld_we_i,
    input  logic [1:0]              ld_sel_i,
    input  logic [AW-1:0]           ld_addr_i,
    input  logic [WORD_W-1:0]       ld_data_i,
    input  logic                    go_i,
    output logic                    busy_o,
    output logic                    start_o,
    output logic [PE_NB*WORD_W-1:0] a_o,
    output logic [WORD_W-1:0]       b_o,
    output logic [WORD_W-1:0]       p_o,
    input  logic                    a_shift_i,
    input  logic                    b_fetch_i,
    input  logic                    p_fetch_i,
    input  logic                    res_push_i,
    input  logic [WORD_W-1:0]       res_i,
    input  logic                    done_i,
    input  logic [AW-1:0]           rd_addr_i,
    output logic [WORD_W-1:0]       rd_data_o,
    output logic                    res_valid_o,
    output logic                    err_o
);

    localparam int unsigned IW   = (s > 1) ? $clog2(s) : 1;
    localparam int unsigned NGRP = (s + PE_NB - 1) / PE_NB;
    localparam int unsigned GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

    state_t          state_q, state_d;
    logic [AW-1:0]   b_idx_q, b_idx_d;
    logic [AW-1:0]   p_idx_q, p_idx_d;
    logic [AW-1:0]   wr_idx_q, wr_idx_d;
    logic [GW-1:0]   a_grp_q, a_grp_d;
    logic            start_q, start_d;
    logic            err_q, err_d;

    logic [WORD_W-1:0] a_mem_q [s];

    logic ld_ok;
    logic ld_in_range;
    logic res_we;

    assign ld_ok       = ld_we_i && (state_q != StRun);
    assign ld_in_range = 32'(ld_addr_i) < s;
    assign res_we      = (state_q == StRun) && res_push_i && (32'(wr_idx_q) < s);

    // A is a flat register array so a whole PE group can be read in parallel.
    always_ff @(posedge clock_i) begin
        if (ld_ok && ld_in_range && (ld_sel_i == LD_A)) begin
            a_mem_q[ld_addr_i[IW-1:0]] <= ld_data_i;
        end
    end

    fios_word_ram #(.Depth(s), .AW(AW), .RegRead(1'b0)) u_b_ram (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .we_i    (ld_ok && ld_in_range && (ld_sel_i == LD_B)),
        .waddr_i (ld_addr_i),
        .wdata_i (ld_data_i),
        .raddr_i (b_idx_q),
        .rdata_o (b_o)
    );

    fios_word_ram #(.Depth(s), .AW(AW), .RegRead(1'b0)) u_p_ram (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .we_i    (ld_ok && ld_in_range && (ld_sel_i == LD_P)),
        .waddr_i (ld_addr_i),
        .wdata_i (ld_data_i),
        .raddr_i (p_idx_q),
        .rdata_o (p_o)
    );

    fios_word_ram #(.Depth(s), .AW(AW), .RegRead(1'b1)) u_res_ram (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .we_i    (res_we),
        .waddr_i (wr_idx_q),
        .wdata_i (res_i),
        .raddr_i (rd_addr_i),
        .rdata_o (rd_data_o)
    );

    // A word group: lanes past the last operand word read as zero.
    always_comb begin
        int unsigned idx;
        a_o = '0;
        idx = 0;
        for (int unsigned k = 0; k < PE_NB; k++) begin
            idx = 32'(a_grp_q) * PE_NB + k;
            if (idx < s) begin
                a_o[k*WORD_W +: WORD_W] = a_mem_q[idx[IW-1:0]];
            end
        end
    end

    // Next-state: FSM transitions, strobe-driven index updates, sticky error.
    always_comb begin
        state_d  = state_q;
        b_idx_d  = b_idx_q;
        p_idx_d  = p_idx_q;
        wr_idx_d = wr_idx_q;
        a_grp_d  = a_grp_q;
        start_d  = 1'b0;
        err_d    = err_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (go_i) begin
                    state_d  = StRun;
                    start_d  = 1'b1;
                    b_idx_d  = '0;
                    p_idx_d  = '0;
                    wr_idx_d = '0;
                    a_grp_d  = '0;
                    err_d    = 1'b0;
                end else if ((state_q == StDone) && ld_we_i) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (ld_we_i) begin
                    err_d = 1'b1;
                end
                if (b_fetch_i) begin
                    b_idx_d = (b_idx_q == AW'(s - 1)) ? '0 : b_idx_q + AW'(1);
                end
                if (p_fetch_i) begin
                    p_idx_d = (p_idx_q == AW'(s - 1)) ? '0 : p_idx_q + AW'(1);
                end
                if (a_shift_i) begin
                    a_grp_d = (a_grp_q == GW'(NGRP - 1)) ? '0 : a_grp_q + GW'(1);
                end
                if (res_push_i) begin
                    if (32'(wr_idx_q) < s) begin
                        wr_idx_d = wr_idx_q + AW'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // Checked against the post-capture count so a same-cycle push counts.
                if (done_i) begin
                    state_d = StDone;
                    if (wr_idx_d != AW'(s)) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q  <= StIdle;
            b_idx_q  <= '0;
            p_idx_q  <= '0;
            wr_idx_q <= '0;
            a_grp_q  <= '0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            b_idx_q  <= b_idx_d;
            p_idx_q  <= p_idx_d;
            wr_idx_q <= wr_idx_d;
            a_grp_q  <= a_grp_d;
            start_q  <= start_d;
            err_q    <= err_d;
        end
    end

    assign busy_o      = (state_q == StRun);
    assign res_valid_o = (state_q == StDone);
    assign start_o     = start_q;
    assign err_o       = err_q;

endmodule
